conv_sequencer: RTL

// Front-end controller for the depth-wise separable convolution datapath.

---
 rtl/conv_sequencer_if.sv | 23 ++
 rtl/conv_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/conv_sequencer_if.sv
// Source-side handshake bundle for conv_sequencer: kernel byte stream plus
// 3-channel image column stream, each with its own valid/ready pair.
// The master modport is the upstream source, the slave modport is the sequencer.
interface conv_sequencer_if;
    logic       k_valid;
    logic       k_ready;
    logic [7:0] k_data;
    logic       i_valid;
    logic       i_ready;
    logic [4:0] i_data_1;
    logic [4:0] i_data_2;
    logic [4:0] i_data_3;

    modport master (
        output k_valid, k_data, i_valid, i_data_1, i_data_2, i_data_3,
        input  k_ready, i_ready
    );

    modport slave (
        input  k_valid, k_data, i_valid, i_data_1, i_data_2, i_data_3,
        output k_ready, i_ready
    );
endinterface

// File: rtl/conv_sequencer.sv
// conv_sequencer: front-end controller for the depth-wise separable
// convolution datapath. Loads KER_LEN kernel bytes paired with the first
// image columns, then streams the rest of the image bubble-free, counts
// datapath results and reports DONE or a sticky ERR to the host.
// Optional feature: define CONV_SEQ_WDOG_EN to add a DRAIN watchdog that
// aborts the job after WDOG cycles without DP_OUT_VALID.
module conv_sequencer #(
    parameter int KER_LEN = 24,
    parameter int IMG_LEN = 122,
    parameter int OUT_LEN = 88,
    parameter int WDOG    = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    conv_sequencer_if.slave  src,
    output logic             dp_reset,
    output logic             dp_in_valid,
    output logic             dp_kernel_valid,
    output logic [7:0]       dp_kernel,
    output logic [4:0]       dp_in_data_1,
    output logic [4:0]       dp_in_data_2,
    output logic [4:0]       dp_in_data_3,
    input  logic             dp_out_valid,
    output logic             busy,
    output logic             done,
    output logic             err
);

    // Counter widths are fixed (5-bit kernel, 7-bit column/result), so
    // reject parameter sets that would make them wrap inside a job.
    if (IMG_LEN < KER_LEN || KER_LEN < 1 || KER_LEN > 32 || IMG_LEN > 128 ||
        OUT_LEN < 1 || OUT_LEN > 127 || WDOG < 1 || WDOG > 256) begin : g_param_check
        $error("conv_sequencer: unsupported parameter set");
    end

    localparam logic [4:0] KER_LAST = 5'(KER_LEN - 1);
    localparam logic [6:0] COL_LAST = 7'(IMG_LEN - 1);
    localparam logic [6:0] OUT_MAX  = 7'(OUT_LEN);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        LOAD,
        STREAM,
        DRAIN
    } state_t;

    state_t     state;
    logic       hold;
    logic [4:0] ker_cnt;
    logic [6:0] col_cnt;
    logic [6:0] out_cnt;
    logic [6:0] out_next;
    logic       pair_valid;
    logic       wdog_hit;

    assign pair_valid = src.k_valid && src.i_valid;

    // In LOAD a kernel byte and an image column move only as a pair, so both
    // readies follow the joint valid; STREAM accepts image columns every cycle.
    assign src.k_ready = (state == LOAD) && pair_valid;
    assign src.i_ready = ((state == LOAD) && pair_valid) || (state == STREAM);

    // Result count including this cycle's DP_OUT_VALID, saturating at OUT_LEN.
    always_comb begin
        out_next = out_cnt;
        if ((state == STREAM || state == DRAIN) && dp_out_valid && (out_cnt < OUT_MAX)) begin
            out_next = out_cnt + 7'd1;
        end
    end

`ifdef CONV_SEQ_WDOG_EN
    localparam logic [7:0] WDOG_LAST = 8'(WDOG - 1);

    logic [7:0] wdog_cnt;

    assign wdog_hit = (state == DRAIN) && !dp_out_valid && (wdog_cnt == WDOG_LAST);

    // Idle-cycle counter for DRAIN, restarted by every datapath result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt <= '0;
        end else if (state != DRAIN || dp_out_valid) begin
            wdog_cnt <= '0;
        end else begin
            wdog_cnt <= wdog_cnt + 8'd1;
        end
    end
`else
    assign wdog_hit = 1'b0;
`endif

    // Job sequencing FSM with registered datapath strobes and host status.
    // 'hold' stretches DP_RESET to two cycles both in CLR and after an abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            hold            <= 1'b0;
            ker_cnt         <= '0;
            col_cnt         <= '0;
            out_cnt         <= '0;
            dp_reset        <= 1'b0;
            dp_in_valid     <= 1'b0;
            dp_kernel_valid <= 1'b0;
            dp_kernel       <= '0;
            dp_in_data_1    <= '0;
            dp_in_data_2    <= '0;
            dp_in_data_3    <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
        end else begin
            done            <= 1'b0;
            dp_in_valid     <= 1'b0;
            dp_kernel_valid <= 1'b0;
            out_cnt         <= out_next;
            case (state)
                IDLE: begin
                    if (hold) begin
                        hold <= 1'b0;
                    end else begin
                        dp_reset <= 1'b0;
                    end
                    if (start) begin
                        state    <= CLR;
                        busy     <= 1'b1;
                        err      <= 1'b0;
                        dp_reset <= 1'b1;
                        hold     <= 1'b1;
                        ker_cnt  <= '0;
                        col_cnt  <= '0;
                        out_cnt  <= '0;
                    end
                end
                CLR: begin
                    if (hold) begin
                        hold <= 1'b0;
                    end else begin
                        dp_reset <= 1'b0;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (pair_valid) begin
                        dp_kernel       <= src.k_data;
                        dp_in_data_1    <= src.i_data_1;
                        dp_in_data_2    <= src.i_data_2;
                        dp_in_data_3    <= src.i_data_3;
                        dp_in_valid     <= 1'b1;
                        dp_kernel_valid <= 1'b1;
                        ker_cnt         <= ker_cnt + 5'd1;
                        col_cnt         <= col_cnt + 7'd1;
                        if (ker_cnt == KER_LAST) begin
                            state <= (col_cnt == COL_LAST) ? DRAIN : STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (!src.i_valid) begin
                        err      <= 1'b1;
                        dp_reset <= 1'b1;
                        hold     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        dp_in_data_1 <= src.i_data_1;
                        dp_in_data_2 <= src.i_data_2;
                        dp_in_data_3 <= src.i_data_3;
                        dp_in_valid  <= 1'b1;
                        col_cnt      <= col_cnt + 7'd1;
                        if (col_cnt == COL_LAST) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (out_next == OUT_MAX) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (wdog_hit) begin
                        err      <= 1'b1;
                        dp_reset <= 1'b1;
                        hold     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
